// File: rtl/num_unit_rr_sched_if.sv
// ---------------------------------------------------------------------------
// num_unit_rr_sched_if
//
// Bundle of every non-clock signal between the round-robin scheduler, its
// requesters and the shared three-operand arithmetic unit.
//
//   slave  modport : the scheduler itself
//   master modport : the surrounding logic (requesters + unit)
//
// Signals:
//   iv_req            per-requester request level
//   iv_numA/B/C       packed operands, requester i on bits [16*i+15:16*i]
//   ov_gnt            one-hot grant pulse
//   ob_busy           scheduler not idle
//   ov16_unit_numA/B/C latched operands driven to the unit
//   ob_unit_start     one-cycle launch strobe to the unit
//   iv16_unit_num     unit result
//   ov_rsp_vld        one-hot response pulse
//   ov16_rsp_num      response data
// ---------------------------------------------------------------------------
interface num_unit_rr_sched_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    iv_req;
    logic [16*NUM_REQ-1:0] iv_numA;
    logic [16*NUM_REQ-1:0] iv_numB;
    logic [16*NUM_REQ-1:0] iv_numC;
    logic [NUM_REQ-1:0]    ov_gnt;
    logic                  ob_busy;
    logic [15:0]           ov16_unit_numA;
    logic [15:0]           ov16_unit_numB;
    logic [15:0]           ov16_unit_numC;
    logic                  ob_unit_start;
    logic [15:0]           iv16_unit_num;
    logic [NUM_REQ-1:0]    ov_rsp_vld;
    logic [15:0]           ov16_rsp_num;

    modport slave (
        input  iv_req, iv_numA, iv_numB, iv_numC, iv16_unit_num,
        output ov_gnt, ob_busy, ov16_unit_numA, ov16_unit_numB,
               ov16_unit_numC, ob_unit_start, ov_rsp_vld, ov16_rsp_num
    );

    modport master (
        output iv_req, iv_numA, iv_numB, iv_numC, iv16_unit_num,
        input  ov_gnt, ob_busy, ov16_unit_numA, ov16_unit_numB,
               ov16_unit_numC, ob_unit_start, ov_rsp_vld, ov16_rsp_num
    );
endinterface

// File: rtl/num_unit_rr_sched.sv
// ---------------------------------------------------------------------------
// num_unit_rr_sched
//
// Round-robin scheduler sharing one 16-bit three-operand arithmetic unit
// between NUM_REQ requesters. The winner's operands are latched and launched
// into the unit, the scheduler waits UNIT_LAT cycles and then returns the
// unit's result to the winner with a one-cycle response pulse.
//
// Parameters:
//   NUM_REQ   number of requesters (2..8)
//   UNIT_LAT  cycles from ob_unit_start to a valid unit result (1..15)
//
// Ports:
//   ib_clk    clock, rising edge
//   ib_rst    synchronous active-high reset
//   bus       num_unit_rr_sched_if.slave (requests, operands, grants, unit
//             launch/result, responses, busy)
//
// Optional feature, macro NUM_UNIT_RR_SCHED_STATS_EN:
//   iv_stat_sel    selects which requester's grant counter to observe
//   ov16_stat_cnt  registered, saturating 16-bit grant count of that requester
// ---------------------------------------------------------------------------
module num_unit_rr_sched #(
    parameter int NUM_REQ  = 4,
    parameter int UNIT_LAT = 2
) (
    input  logic                       ib_clk,
    input  logic                       ib_rst,
    num_unit_rr_sched_if.slave         bus
`ifdef NUM_UNIT_RR_SCHED_STATS_EN
    ,
    input  logic [$clog2(NUM_REQ)-1:0] iv_stat_sel,
    output logic [15:0]                ov16_stat_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     win_idx_q, win_idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   rsp_vld_q, rsp_vld_d;
    logic                 start_q, start_d;
    logic                 busy_q, busy_d;
    logic [15:0]          unit_a_q, unit_a_d;
    logic [15:0]          unit_b_q, unit_b_d;
    logic [15:0]          unit_c_q, unit_c_d;
    logic [15:0]          rsp_num_q, rsp_num_d;

    logic [15:0]          op_a [NUM_REQ];
    logic [15:0]          op_b [NUM_REQ];
    logic [15:0]          op_c [NUM_REQ];

    logic                 arb_found;
    logic [IDX_W-1:0]     arb_win;
    logic [IDX_W-1:0]     arb_next_ptr;

    // Unpack the flat operand buses into per-requester words.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i] = bus.iv_numA[16*i +: 16];
            op_b[i] = bus.iv_numB[16*i +: 16];
            op_c[i] = bus.iv_numC[16*i +: 16];
        end
    end

    // Round-robin search: first set request at or above the pointer,
    // wrapping modulo NUM_REQ (works for non-power-of-two NUM_REQ too).
    always_comb begin
        arb_found = 1'b0;
        arb_win   = ptr_q;
        for (int o = 0; o < NUM_REQ; o++) begin
            int               s;
            logic [IDX_W-1:0] idx;
            s = int'(ptr_q) + o;
            if (s >= NUM_REQ) begin
                s = s - NUM_REQ;
            end
            idx = IDX_W'(s);
            if (!arb_found && bus.iv_req[idx]) begin
                arb_found = 1'b1;
                arb_win   = idx;
            end
        end
        arb_next_ptr = (arb_win == IDX_W'(NUM_REQ - 1)) ? '0 : arb_win + 1'b1;
    end

    // Next-state logic. Grant, start and response are pulses, so they
    // default to zero; operand and response registers hold by default.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_idx_d = win_idx_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        start_d   = 1'b0;
        rsp_vld_d = '0;
        unit_a_d  = unit_a_q;
        unit_b_d  = unit_b_q;
        unit_c_d  = unit_c_q;
        rsp_num_d = rsp_num_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    unit_a_d         = op_a[arb_win];
                    unit_b_d         = op_b[arb_win];
                    unit_c_d         = op_c[arb_win];
                    gnt_d[arb_win]   = 1'b1;
                    start_d          = 1'b1;
                    win_idx_d        = arb_win;
                    cnt_d            = CNT_W'(UNIT_LAT);
                    ptr_d            = arb_next_ptr;
                    state_d          = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                // Last latency cycle: the unit result is valid now.
                if (cnt_q == CNT_W'(1)) begin
                    rsp_num_d            = bus.iv16_unit_num;
                    rsp_vld_d[win_idx_q] = 1'b1;
                    state_d              = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset; an in-flight
    // operation is simply dropped.
    always_ff @(posedge ib_clk) begin
        if (ib_rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            win_idx_q <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            rsp_vld_q <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            unit_a_q  <= '0;
            unit_b_q  <= '0;
            unit_c_q  <= '0;
            rsp_num_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_idx_q <= win_idx_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            rsp_vld_q <= rsp_vld_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            unit_a_q  <= unit_a_d;
            unit_b_q  <= unit_b_d;
            unit_c_q  <= unit_c_d;
            rsp_num_q <= rsp_num_d;
        end
    end

    assign bus.ov_gnt         = gnt_q;
    assign bus.ob_busy        = busy_q;
    assign bus.ov16_unit_numA = unit_a_q;
    assign bus.ov16_unit_numB = unit_b_q;
    assign bus.ov16_unit_numC = unit_c_q;
    assign bus.ob_unit_start  = start_q;
    assign bus.ov_rsp_vld     = rsp_vld_q;
    assign bus.ov16_rsp_num   = rsp_num_q;

`ifdef NUM_UNIT_RR_SCHED_STATS_EN
    logic [15:0] stat_cnt_q [NUM_REQ];
    logic [15:0] stat_cnt_d [NUM_REQ];
    logic [15:0] stat_out_q, stat_out_d;

    // Saturating per-requester grant counters, bumped when a grant issues.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_cnt_d[i] = stat_cnt_q[i];
            if (gnt_d[i] && (stat_cnt_q[i] != 16'hFFFF)) begin
                stat_cnt_d[i] = stat_cnt_q[i] + 16'd1;
            end
        end
        stat_out_d = '0;
        if (int'(iv_stat_sel) < NUM_REQ) begin
            stat_out_d = stat_cnt_q[iv_stat_sel];
        end
    end

    always_ff @(posedge ib_clk) begin
        if (ib_rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_cnt_q[i] <= '0;
            end
            stat_out_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_cnt_q[i] <= stat_cnt_d[i];
            end
            stat_out_q <= stat_out_d;
        end
    end

    assign ov16_stat_cnt = stat_out_q;
`endif

endmodule

// File: tb/tb_num_unit_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_num_unit_rr_sched
//
// Directed bench for num_unit_rr_sched with NUM_REQ=4, UNIT_LAT=2. A small
// model of the shared unit captures A*B+C (or a fixed constant) when it sees
// ob_unit_start, so its result is ready for the scheduler's sampling edge.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_num_unit_rr_sched;

    localparam int NUM_REQ  = 4;
    localparam int UNIT_LAT = 2;

    logic        ib_clk = 1'b0;
    logic        ib_rst = 1'b1;
    logic [15:0] op_a [NUM_REQ];
    logic [15:0] op_b [NUM_REQ];
    logic [15:0] op_c [NUM_REQ];
    logic [15:0] unit_q = '0;
    logic        unit_const_en = 1'b0;
    logic [15:0] unit_const = '0;
    int          n_tests = 0;
    int          n_fail  = 0;

`ifdef NUM_UNIT_RR_SCHED_STATS_EN
    logic [1:0]  stat_sel = '0;
    logic [15:0] stat_cnt;
`endif

    num_unit_rr_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

    num_unit_rr_sched #(
        .NUM_REQ  (NUM_REQ),
        .UNIT_LAT (UNIT_LAT)
    ) dut (
        .ib_clk (ib_clk),
        .ib_rst (ib_rst),
        .bus    (bus)
`ifdef NUM_UNIT_RR_SCHED_STATS_EN
        ,
        .iv_stat_sel   (stat_sel),
        .ov16_stat_cnt (stat_cnt)
`endif
    );

    // Free-running 10 ns clock.
    always #5 ib_clk = ~ib_clk;

    // Pack the per-requester operand words onto the interface buses.
    assign bus.iv_numA      = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign bus.iv_numB      = {op_b[3], op_b[2], op_b[1], op_b[0]};
    assign bus.iv_numC      = {op_c[3], op_c[2], op_c[1], op_c[0]};
    assign bus.iv16_unit_num = unit_q;

    function automatic logic [15:0] unit_f(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c);
        return a * b + c;
    endfunction

    // Shared unit model: result is ready one edge after the launch strobe,
    // i.e. by the scheduler's sampling edge for UNIT_LAT=2.
    always @(posedge ib_clk) begin
        if (bus.ob_unit_start) begin
            unit_q <= unit_const_en ? unit_const
                      : unit_f(bus.ov16_unit_numA, bus.ov16_unit_numB, bus.ov16_unit_numC);
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Two reset edges with requests dropped.
    task automatic apply_reset();
        bus.iv_req = '0;
        ib_rst = 1'b1;
        @(negedge ib_clk);
        @(negedge ib_clk);
        ib_rst = 1'b0;
    endtask

    // Wait (bounded) for the scheduler to return to idle.
    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge ib_clk);
            if (bus.ob_busy === 1'b0) break;
        end
        n_tests++;
        if (bus.ob_busy !== 1'b0) begin
            $display("[TB] FAIL wait_idle: got busy=%b expected 0", bus.ob_busy);
            n_fail++;
        end
    endtask

    // Reset state: every output is zero.
    task automatic test_reset();
        apply_reset();
        n_tests++;
        if (bus.ov_gnt !== 4'b0000) begin
            $display("[TB] FAIL reset_gnt: got %b expected 0000", bus.ov_gnt); n_fail++;
        end
        n_tests++;
        if (bus.ov_rsp_vld !== 4'b0000) begin
            $display("[TB] FAIL reset_rsp_vld: got %b expected 0000", bus.ov_rsp_vld); n_fail++;
        end
        n_tests++;
        if ({bus.ob_unit_start, bus.ob_busy} !== 2'b00) begin
            $display("[TB] FAIL reset_start_busy: got %b expected 00",
                     {bus.ob_unit_start, bus.ob_busy}); n_fail++;
        end
        n_tests++;
        if ({bus.ov16_unit_numA, bus.ov16_unit_numB, bus.ov16_unit_numC, bus.ov16_rsp_num} !== 64'h0) begin
            $display("[TB] FAIL reset_data: got %h expected 0",
                     {bus.ov16_unit_numA, bus.ov16_unit_numB, bus.ov16_unit_numC, bus.ov16_rsp_num});
            n_fail++;
        end
    endtask

    // Single requester 1 with A=3/B=4/C=5; unit returns 16'h1234.
    task automatic test_single();
        int busy_cycles;
        apply_reset();
        op_a[1] = 16'd3; op_b[1] = 16'd4; op_c[1] = 16'd5;
        unit_const_en = 1'b1; unit_const = 16'h1234;
        bus.iv_req = 4'b0010;
        @(negedge ib_clk);
        busy_cycles = (bus.ob_busy === 1'b1) ? 1 : 0;
        n_tests++;
        if (bus.ov_gnt !== 4'b0010 || bus.ob_unit_start !== 1'b1) begin
            $display("[TB] FAIL single_gnt: got gnt=%b start=%b expected 0010/1",
                     bus.ov_gnt, bus.ob_unit_start); n_fail++;
        end
        n_tests++;
        if ({bus.ov16_unit_numA, bus.ov16_unit_numB, bus.ov16_unit_numC} !== {16'd3, 16'd4, 16'd5}) begin
            $display("[TB] FAIL single_ops: got %h expected 000300040005",
                     {bus.ov16_unit_numA, bus.ov16_unit_numB, bus.ov16_unit_numC}); n_fail++;
        end
        bus.iv_req = 4'b0000;
        @(negedge ib_clk);
        if (bus.ob_busy === 1'b1) busy_cycles++;
        n_tests++;
        if (bus.ov_gnt !== 4'b0000 || bus.ob_unit_start !== 1'b0 || bus.ov_rsp_vld !== 4'b0000) begin
            $display("[TB] FAIL single_mid: got gnt=%b start=%b rsp=%b expected 0000/0/0000",
                     bus.ov_gnt, bus.ob_unit_start, bus.ov_rsp_vld); n_fail++;
        end
        @(negedge ib_clk);
        if (bus.ob_busy === 1'b1) busy_cycles++;
        n_tests++;
        if (bus.ov_rsp_vld !== 4'b0010 || bus.ov16_rsp_num !== 16'h1234) begin
            $display("[TB] FAIL single_rsp: got rsp=%b num=%h expected 0010/1234",
                     bus.ov_rsp_vld, bus.ov16_rsp_num); n_fail++;
        end
        @(negedge ib_clk);
        if (bus.ob_busy === 1'b1) busy_cycles++;
        n_tests++;
        if (bus.ov_rsp_vld !== 4'b0000 || bus.ov16_rsp_num !== 16'h1234 || bus.ov16_unit_numA !== 16'd3) begin
            $display("[TB] FAIL single_hold: got rsp=%b num=%h A=%h expected 0000/1234/0003",
                     bus.ov_rsp_vld, bus.ov16_rsp_num, bus.ov16_unit_numA); n_fail++;
        end
        n_tests++;
        if (busy_cycles != 3) begin
            $display("[TB] FAIL single_busy_len: got %0d expected 3", busy_cycles); n_fail++;
        end
        unit_const_en = 1'b0;
    endtask

    // All four requests held: grants 0,1,2,3,0 spaced four cycles apart,
    // each response carrying that requester's A*B+C.
    task automatic test_round_robin();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int n_gnt = 0;
        int n_rsp = 0;
        int last_cyc = 0;
        logic [3:0] exp_vec;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i] = 16'h0100 + 16'(i);
            op_b[i] = 16'h0020 + 16'(i);
            op_c[i] = 16'h0003 + 16'(i);
        end
        bus.iv_req = 4'b1111;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge ib_clk);
            if (bus.ov_gnt !== 4'b0000 && n_gnt < 5) begin
                exp_vec = 4'b0001 << exp_order[n_gnt];
                n_tests++;
                if (bus.ov_gnt !== exp_vec) begin
                    $display("[TB] FAIL rr_gnt%0d: got %b expected %b", n_gnt, bus.ov_gnt, exp_vec);
                    n_fail++;
                end
                if (n_gnt > 0) begin
                    n_tests++;
                    if (cyc - last_cyc != UNIT_LAT + 2) begin
                        $display("[TB] FAIL rr_spacing%0d: got %0d expected %0d",
                                 n_gnt, cyc - last_cyc, UNIT_LAT + 2); n_fail++;
                    end
                end
                last_cyc = cyc;
                n_gnt++;
            end
            if (bus.ov_rsp_vld !== 4'b0000 && n_rsp < 5) begin
                exp_vec = 4'b0001 << exp_order[n_rsp];
                n_tests++;
                if (bus.ov_rsp_vld !== exp_vec ||
                    bus.ov16_rsp_num !== unit_f(op_a[exp_order[n_rsp]], op_b[exp_order[n_rsp]],
                                                op_c[exp_order[n_rsp]])) begin
                    $display("[TB] FAIL rr_rsp%0d: got %b/%h expected %b/%h", n_rsp,
                             bus.ov_rsp_vld, bus.ov16_rsp_num, exp_vec,
                             unit_f(op_a[exp_order[n_rsp]], op_b[exp_order[n_rsp]],
                                    op_c[exp_order[n_rsp]])); n_fail++;
                end
                n_rsp++;
            end
        end
        bus.iv_req = 4'b0000;
        n_tests++;
        if (n_gnt != 5 || n_rsp != 5) begin
            $display("[TB] FAIL rr_count: got %0d grants %0d rsps expected 5 5", n_gnt, n_rsp);
            n_fail++;
        end
        wait_idle();
    endtask

    // Pointer parked at 3 (after serving requester 2), requests 1001:
    // requester 3 wins first, then the pointer wraps to 0.
    task automatic test_wrap();
        apply_reset();
        bus.iv_req = 4'b0100;
        @(negedge ib_clk);
        bus.iv_req = 4'b0000;
        wait_idle();
        bus.iv_req = 4'b1001;
        @(negedge ib_clk);
        n_tests++;
        if (bus.ov_gnt !== 4'b1000) begin
            $display("[TB] FAIL wrap_first: got %b expected 1000", bus.ov_gnt); n_fail++;
        end
        repeat (UNIT_LAT + 2) @(negedge ib_clk);
        n_tests++;
        if (bus.ov_gnt !== 4'b0001) begin
            $display("[TB] FAIL wrap_second: got %b expected 0001", bus.ov_gnt); n_fail++;
        end
        bus.iv_req = 4'b0000;
        wait_idle();
    endtask

    // Requester 2 raises and drops its request while requester 0 is served.
    task automatic test_withdrawal();
        int seen_gnt2 = 0;
        int seen_rsp2 = 0;
        int seen_rsp0 = 0;
        apply_reset();
        bus.iv_req = 4'b0001;
        @(negedge ib_clk);
        bus.iv_req = 4'b0100;
        @(negedge ib_clk);
        bus.iv_req = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            if (bus.ov_gnt[2] === 1'b1) seen_gnt2++;
            if (bus.ov_rsp_vld[2] === 1'b1) seen_rsp2++;
            if (bus.ov_rsp_vld === 4'b0001) seen_rsp0++;
            @(negedge ib_clk);
        end
        n_tests++;
        if (seen_gnt2 != 0 || seen_rsp2 != 0) begin
            $display("[TB] FAIL withdraw_req2: got gnt=%0d rsp=%0d expected 0 0", seen_gnt2, seen_rsp2);
            n_fail++;
        end
        n_tests++;
        if (seen_rsp0 != 1) begin
            $display("[TB] FAIL withdraw_rsp0: got %0d expected 1", seen_rsp0); n_fail++;
        end
    endtask

    // Reset one cycle after granting requester 2: everything clears, no
    // response appears, and the pointer restarts at requester 0.
    task automatic test_reset_mid();
        int seen_rsp = 0;
        apply_reset();
        bus.iv_req = 4'b0100;
        @(negedge ib_clk);
        n_tests++;
        if (bus.ov_gnt !== 4'b0100) begin
            $display("[TB] FAIL rstmid_gnt: got %b expected 0100", bus.ov_gnt); n_fail++;
        end
        bus.iv_req = 4'b0000;
        ib_rst = 1'b1;
        @(negedge ib_clk);
        ib_rst = 1'b0;
        n_tests++;
        if ({bus.ov_gnt, bus.ov_rsp_vld, bus.ob_unit_start, bus.ob_busy} !== 10'b0 ||
            {bus.ov16_unit_numA, bus.ov16_rsp_num} !== 32'h0) begin
            $display("[TB] FAIL rstmid_clear: got %b %h expected all zero",
                     {bus.ov_gnt, bus.ov_rsp_vld, bus.ob_unit_start, bus.ob_busy},
                     {bus.ov16_unit_numA, bus.ov16_rsp_num}); n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge ib_clk);
            if (bus.ov_rsp_vld !== 4'b0000) seen_rsp++;
        end
        n_tests++;
        if (seen_rsp != 0) begin
            $display("[TB] FAIL rstmid_no_rsp: got %0d expected 0", seen_rsp); n_fail++;
        end
        bus.iv_req = 4'b1111;
        @(negedge ib_clk);
        bus.iv_req = 4'b0000;
        n_tests++;
        if (bus.ov_gnt !== 4'b0001) begin
            $display("[TB] FAIL rstmid_next: got %b expected 0001", bus.ov_gnt); n_fail++;
        end
        wait_idle();
    endtask

    // Requester 1 keeps requesting and changes operands right after its
    // grant: latched operands hold, and the second operation uses new ones.
    task automatic test_back_to_back();
        apply_reset();
        op_a[1] = 16'd10; op_b[1] = 16'd2; op_c[1] = 16'd3;
        bus.iv_req = 4'b0010;
        @(negedge ib_clk);
        n_tests++;
        if (bus.ov_gnt !== 4'b0010 || bus.ov16_unit_numA !== 16'd10) begin
            $display("[TB] FAIL b2b_gnt1: got %b/%h expected 0010/000a", bus.ov_gnt, bus.ov16_unit_numA);
            n_fail++;
        end
        op_a[1] = 16'd7; op_b[1] = 16'd5; op_c[1] = 16'd1;
        @(negedge ib_clk);
        n_tests++;
        if (bus.ov16_unit_numA !== 16'd10) begin
            $display("[TB] FAIL b2b_hold: got %h expected 000a", bus.ov16_unit_numA); n_fail++;
        end
        @(negedge ib_clk);
        n_tests++;
        if (bus.ov_rsp_vld !== 4'b0010 || bus.ov16_rsp_num !== 16'd23) begin
            $display("[TB] FAIL b2b_rsp1: got %b/%h expected 0010/0017", bus.ov_rsp_vld, bus.ov16_rsp_num);
            n_fail++;
        end
        @(negedge ib_clk);
        @(negedge ib_clk);
        n_tests++;
        if (bus.ov_gnt !== 4'b0010 || bus.ov16_unit_numA !== 16'd7) begin
            $display("[TB] FAIL b2b_gnt2: got %b/%h expected 0010/0007", bus.ov_gnt, bus.ov16_unit_numA);
            n_fail++;
        end
        bus.iv_req = 4'b0000;
        @(negedge ib_clk);
        @(negedge ib_clk);
        n_tests++;
        if (bus.ov_rsp_vld !== 4'b0010 || bus.ov16_rsp_num !== 16'd36) begin
            $display("[TB] FAIL b2b_rsp2: got %b/%h expected 0010/0024", bus.ov_rsp_vld, bus.ov16_rsp_num);
            n_fail++;
        end
        wait_idle();
    endtask

`ifdef NUM_UNIT_RR_SCHED_STATS_EN
    // Five grants to requester 1, then read back counters 1 and 0.
    task automatic test_stats();
        int n_gnt = 0;
        apply_reset();
        bus.iv_req = 4'b0010;
        for (int i = 0; i < 30 && n_gnt < 5; i++) begin
            @(negedge ib_clk);
            if (bus.ov_gnt === 4'b0010) n_gnt++;
        end
        bus.iv_req = 4'b0000;
        stat_sel = 2'd1;
        @(negedge ib_clk);
        @(negedge ib_clk);
        n_tests++;
        if (stat_cnt !== 16'd5) begin
            $display("[TB] FAIL stats_req1: got %0d expected 5", stat_cnt); n_fail++;
        end
        stat_sel = 2'd0;
        @(negedge ib_clk);
        @(negedge ib_clk);
        n_tests++;
        if (stat_cnt !== 16'd0) begin
            $display("[TB] FAIL stats_req0: got %0d expected 0", stat_cnt); n_fail++;
        end
        wait_idle();
    endtask
`endif

    // Run every scenario in order, then print the summary.
    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i] = '0; op_b[i] = '0; op_c[i] = '0;
        end
        bus.iv_req = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_withdrawal();
        test_reset_mid();
        test_back_to_back();
`ifdef NUM_UNIT_RR_SCHED_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
